dmem_responder: RTL and testbench

- Data-memory slave at the far end of the pipelined core's MEM-stage port (mem_w, address, store data, dm_ctrl; load data returned).
- Decodes dm_ctrl into byte/half/word access and writes store data into a word-organised RAM through byte-lane strobes.
- Sign- or zero-extends load data.
- Also hosts a small memory-mapped register window: free-running cycle counter, LED register, misaligned-store counter.

---
 rtl/dmem_responder_pkg.sv | 44 ++++
 rtl/dm_lane_ext.sv | 47 ++++
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the data-memory responder.
//   - dm_ctrl access codes (3 bits; undefined codes behave as word)
//   - access-size classification and alignment helpers
//   - MMIO register word offsets inside the 16-byte window (addr[3:2])
package dmem_responder_pkg;

  localparam logic [2:0] DM_WORD   = 3'b000;
  localparam logic [2:0] DM_HALF_S = 3'b001;
  localparam logic [2:0] DM_HALF_U = 3'b010;
  localparam logic [2:0] DM_BYTE_S = 3'b011;
  localparam logic [2:0] DM_BYTE_U = 3'b100;

  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_HALF = 2'd1,
    SZ_BYTE = 2'd2
  } dm_size_e;

  localparam logic [1:0] MMIO_CYCLE  = 2'd0;
  localparam logic [1:0] MMIO_LED    = 2'd1;
  localparam logic [1:0] MMIO_MISAL  = 2'd2;
  localparam logic [1:0] MMIO_STATUS = 2'd3;

  function automatic dm_size_e dm_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_HALF_S, DM_HALF_U: return SZ_HALF;
      DM_BYTE_S, DM_BYTE_U: return SZ_BYTE;
      default:              return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_is_signed(input logic [2:0] ctrl);
    return (ctrl == DM_HALF_S) || (ctrl == DM_BYTE_S);
  endfunction

  function automatic logic dm_misaligned(input dm_size_e size, input logic [1:0] lo);
    case (size)
      SZ_WORD: return lo != 2'b00;
      SZ_HALF: return lo[0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lane_ext.sv
// Load-lane selector: picks the byte/half lane of a 32-bit word and sign- or
// zero-extends it according to dm_ctrl. Misaligned accesses return 0.
// Ports:
//   word     in  32  source word (RAM or MMIO)
//   byte_off in  2   addr[1:0]
//   dm_ctrl  in  3   access width/signedness code
//   ext      out 32  extended load value
module dm_lane_ext
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] ext
);

  dm_size_e    size;
  logic        sgn;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  assign size     = dm_size(dm_ctrl);
  assign sgn      = dm_is_signed(dm_ctrl);
  assign half_sel = byte_off[1] ? word[31:16] : word[15:0];

  always_comb begin
    byte_sel = word[7:0];
    case (byte_off)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
  end

  always_comb begin
    ext = '0;
    if (!dm_misaligned(size, byte_off)) begin
      case (size)
        SZ_HALF: ext = {{16{sgn & half_sel[15]}}, half_sel};
        SZ_BYTE: ext = {{24{sgn & byte_sel[7]}}, byte_sel};
        default: ext = word;
      endcase
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the core's MEM-stage port: word-organised RAM with
// byte-lane strobes, zero-latency extended loads, and a 16-byte MMIO window
// (CYCLE, LED, MISAL, STATUS).
// Ports:
//   clk       in  1   clock, rising edge
//   rst       in  1   asynchronous active-low reset
//   mem_w     in  1   store enable
//   addr      in  32  byte address
//   din       in  32  store data (low lanes used for SB/SH)
//   dm_ctrl   in  3   access width/signedness
//   dout      out 32  combinational load data
//   led       out 16  LED register
//   store_err out 1   sticky misaligned/out-of-range/bad-MMIO store flag
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] din,
  input  logic [2:0]  dm_ctrl,
  output logic [31:0] dout,
  output logic [15:0] led,
  output logic        store_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   ram [DEPTH_WORDS];
  logic [31:0]   cycle_cnt;
  logic [31:0]   misal_cnt;

  dm_size_e      size;
  logic          misal;
  logic          is_mmio;
  logic          in_ram;
  logic [AW-1:0] widx;
  logic [1:0]    moff;
  logic [31:0]   mmio_word;
  logic [31:0]   src_word;
  logic [3:0]    strb;
  logic [31:0]   wdata;
  logic          ram_we;
  logic          mmio_wr;
  logic          err_set;
  logic          err_clr;

  assign size    = dm_size(dm_ctrl);
  assign misal   = dm_misaligned(size, addr[1:0]);
  assign is_mmio = addr[31:4] == MMIO_BASE[31:4];
  assign in_ram  = !is_mmio && (addr[31:AW+2] == '0);
  assign widx    = addr[AW+1:2];
  assign moff    = addr[3:2];

  // ---------------- load path ----------------
  always_comb begin
    mmio_word = '0;
    case (moff)
      MMIO_CYCLE:  mmio_word = cycle_cnt;
      MMIO_LED:    mmio_word = {16'h0000, led};
      MMIO_MISAL:  mmio_word = misal_cnt;
      MMIO_STATUS: mmio_word = {31'b0, store_err};
      default:     mmio_word = '0;
    endcase
  end

  // Sub-word MMIO loads and unmapped addresses feed 0 into the lane block.
  always_comb begin
    src_word = '0;
    if (is_mmio) begin
      if (size == SZ_WORD) src_word = mmio_word;
    end else if (in_ram) begin
      src_word = ram[widx];
    end
  end

  dm_lane_ext u_lane_ext (
    .word     (src_word),
    .byte_off (addr[1:0]),
    .dm_ctrl  (dm_ctrl),
    .ext      (dout)
  );

  // ---------------- store path ----------------
  always_comb begin
    strb  = 4'b0000;
    wdata = din;
    case (size)
      SZ_WORD: strb = 4'b1111;
      SZ_HALF: begin
        strb  = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      SZ_BYTE: begin
        strb  = 4'b0001 << addr[1:0];
        wdata = {4{din[7:0]}};
      end
      default: strb = 4'b0000;
    endcase
  end

  // rst gates the RAM write so a store under reset is dropped; RAM has no reset.
  assign ram_we  = mem_w && rst && in_ram && !misal;
  assign mmio_wr = mem_w && is_mmio && (size == SZ_WORD) && !misal;
  assign err_set = mem_w && (misal || (is_mmio && size != SZ_WORD) || (!is_mmio && !in_ram));
  assign err_clr = mmio_wr && (moff == MMIO_STATUS) && din[0];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) ram[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      misal_cnt <= '0;
      led       <= '0;
      store_err <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (mem_w && misal && (misal_cnt != 32'hFFFF_FFFF)) misal_cnt <= misal_cnt + 32'd1;
      if (mmio_wr && (moff == MMIO_LED)) led <= din[15:0];
      // A new error in the same cycle as a clear keeps the flag set.
      if (err_set)      store_err <= 1'b1;
      else if (err_clr) store_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] din;
  logic [2:0]  dm_ctrl;
  logic [31:0] dout;
  logic [15:0] led;
  logic        store_err;

  int n_chk  = 0;
  int n_fail = 0;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .mem_w     (mem_w),
    .addr      (addr),
    .din       (din),
    .dm_ctrl   (dm_ctrl),
    .dout      (dout),
    .led       (led),
    .store_err (store_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
    logic        chk;
    logic [31:0] exp_dout;
    logic        exp_err;
    logic [15:0] exp_led;
  } vec_t;

  vec_t tbl[$];

  // Behavioural model: byte-addressed memory plus register values.
  logic [7:0]  mem_b [4096];
  bit          known [4096];
  logic [15:0] m_led;
  logic        m_err;
  logic [31:0] m_misal;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ctrl_bytes(input logic [2:0] c);
    if (c == 3'd1 || c == 3'd2) return 2;
    if (c == 3'd3 || c == 3'd4) return 1;
    return 4;
  endfunction

  task automatic model_load(input logic [31:0] a, input logic [2:0] c,
                            output logic [31:0] v, output bit ok);
    int w;
    logic [31:0] raw;
    w  = ctrl_bytes(c);
    ok = 1'b1;
    v  = '0;
    if ((a % w) != 0) v = '0;
    else if (a[31:4] == 28'hFFFF000) begin
      if (w != 4) v = '0;
      else case (a[3:0])
        4'd4:    v = {16'h0, m_led};
        4'd8:    v = m_misal;
        4'd12:   v = {31'b0, m_err};
        default: ok = 1'b0;
      endcase
    end else if (a >= 32'd4096) v = '0;
    else begin
      raw = '0;
      for (int i = 0; i < w; i++) begin
        if (!known[int'(a) + i]) ok = 1'b0;
        raw = raw | (32'(mem_b[int'(a) + i]) << (8 * i));
      end
      if ((c == 3'd1 || c == 3'd3) && raw[8*w-1])
        raw = raw | ~((32'd1 << (8 * w)) - 32'd1);
      v = raw;
    end
  endtask

  task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    int w;
    bit set, clr;
    w   = ctrl_bytes(c);
    set = 1'b0;
    clr = 1'b0;
    if ((a % w) != 0) begin
      set = 1'b1;
      if (m_misal != 32'hFFFF_FFFF) m_misal = m_misal + 1;
    end else if (a[31:4] == 28'hFFFF000) begin
      if (w != 4) set = 1'b1;
      else if (a[3:0] == 4'd4) m_led = d[15:0];
      else if (a[3:0] == 4'd12 && d[0]) clr = 1'b1;
    end else if (a >= 32'd4096) set = 1'b1;
    else begin
      for (int i = 0; i < w; i++) begin
        mem_b[int'(a) + i] = d[8*i +: 8];
        known[int'(a) + i] = 1'b1;
      end
    end
    if (set) m_err = 1'b1;
    else if (clr) m_err = 1'b0;
  endtask

  // Called just after a rising edge; leaves just after the next one.
  task automatic cycle_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] c);
    logic [31:0] exp;
    bit ok;
    mem_w = we; addr = a; din = d; dm_ctrl = c;
    @(negedge clk);
    model_load(a, c, exp, ok);
    if (ok) check("rand_dout", dout, exp);
    check("rand_led", {16'h0, led}, {16'h0, m_led});
    check("rand_err", {31'b0, store_err}, {31'b0, m_err});
    @(posedge clk);
    if (we) model_store(a, d, c);
    #1;
  endtask

  initial begin
    logic [31:0] c1, c2, ra, rd;
    logic        rw;
    logic [2:0]  rc;
    int          kind;

    //         we    addr           din            ctrl  chk  exp_dout       err  led
    tbl.push_back('{1'b1, 32'h10,       32'h8899AABB, 3'd0, 1'b0, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'h8899AABB, 1'b0, 16'h0});
    tbl.push_back('{1'b1, 32'h11,       32'h000000CC, 3'd3, 1'b0, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'h8899CCBB, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h11,       32'h0,        3'd3, 1'b1, 32'hFFFFFFCC, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h11,       32'h0,        3'd4, 1'b1, 32'h000000CC, 1'b0, 16'h0});
    tbl.push_back('{1'b1, 32'h12,       32'h00007F01, 3'd1, 1'b0, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h12,       32'h0,        3'd1, 1'b1, 32'h00007F01, 1'b0, 16'h0});
    tbl.push_back('{1'b1, 32'h12,       32'h00008001, 3'd1, 1'b0, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h12,       32'h0,        3'd1, 1'b1, 32'hFFFF8001, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h12,       32'h0,        3'd2, 1'b1, 32'h00008001, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'h8001CCBB, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h13,       32'h0,        3'd3, 1'b1, 32'hFFFFFF80, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        3'd4, 1'b1, 32'h000000BB, 1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        3'd5, 1'b1, 32'h8001CCBB, 1'b0, 16'h0});
    tbl.push_back('{1'b1, 32'h20,       32'hCAFEF00D, 3'd0, 1'b0, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b1, 32'h21,       32'h12345678, 3'd0, 1'b1, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'h20,       32'h0,        3'd0, 1'b1, 32'hCAFEF00D, 1'b1, 16'h0});
    tbl.push_back('{1'b0, 32'hFFFF0008, 32'h0,        3'd0, 1'b1, 32'h1,        1'b1, 16'h0});
    tbl.push_back('{1'b0, 32'hFFFF000C, 32'h0,        3'd0, 1'b1, 32'h1,        1'b1, 16'h0});
    tbl.push_back('{1'b1, 32'hFFFF000C, 32'h1,        3'd0, 1'b1, 32'h1,        1'b1, 16'h0});
    tbl.push_back('{1'b0, 32'hFFFF000C, 32'h0,        3'd0, 1'b1, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b1, 32'hFFFF0004, 32'hDEADBEEF, 3'd0, 1'b1, 32'h0,        1'b0, 16'h0});
    tbl.push_back('{1'b0, 32'hFFFF0004, 32'h0,        3'd0, 1'b1, 32'h0000BEEF, 1'b0, 16'hBEEF});
    tbl.push_back('{1'b0, 32'h13,       32'h0,        3'd1, 1'b1, 32'h0,        1'b0, 16'hBEEF});
    tbl.push_back('{1'b0, 32'h12,       32'h0,        3'd0, 1'b1, 32'h0,        1'b0, 16'hBEEF});
    tbl.push_back('{1'b1, 32'h1000,     32'h55,       3'd0, 1'b1, 32'h0,        1'b0, 16'hBEEF});
    tbl.push_back('{1'b0, 32'hFFFF0008, 32'h0,        3'd0, 1'b1, 32'h1,        1'b1, 16'hBEEF});
    tbl.push_back('{1'b0, 32'hFFFF0004, 32'h0,        3'd1, 1'b1, 32'h0,        1'b1, 16'hBEEF});
    tbl.push_back('{1'b1, 32'hFFFF000C, 32'h1,        3'd0, 1'b1, 32'h1,        1'b1, 16'hBEEF});
    tbl.push_back('{1'b1, 32'hFFFF0004, 32'h1234,     3'd1, 1'b1, 32'h0,        1'b0, 16'hBEEF});
    tbl.push_back('{1'b0, 32'hFFFF0004, 32'h0,        3'd0, 1'b1, 32'h0000BEEF, 1'b1, 16'hBEEF});
    tbl.push_back('{1'b1, 32'hFFFF000C, 32'h0,        3'd0, 1'b1, 32'h1,        1'b1, 16'hBEEF});
    tbl.push_back('{1'b0, 32'hFFFF000C, 32'h0,        3'd0, 1'b1, 32'h1,        1'b1, 16'hBEEF});
    tbl.push_back('{1'b1, 32'h10,       32'h11111111, 3'd0, 1'b1, 32'h8001CCBB, 1'b1, 16'hBEEF});
    tbl.push_back('{1'b0, 32'h10,       32'h0,        3'd0, 1'b1, 32'h11111111, 1'b1, 16'hBEEF});

    rst = 1'b0; mem_w = 1'b0; addr = 32'hFFFF0000; din = '0; dm_ctrl = 3'd0;
    #3;
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_err", {31'b0, store_err}, 32'h0);
    check("reset_cycle", dout, 32'h0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      mem_w = tbl[i].we; addr = tbl[i].a; din = tbl[i].d; dm_ctrl = tbl[i].c;
      @(negedge clk);
      if (tbl[i].chk) check($sformatf("vec%0d_dout", i), dout, tbl[i].exp_dout);
      check($sformatf("vec%0d_err", i), {31'b0, store_err}, {31'b0, tbl[i].exp_err});
      check($sformatf("vec%0d_led", i), {16'h0, led}, {16'h0, tbl[i].exp_led});
      @(posedge clk); #1;
    end

    // Async reset in the middle of a pending LED store.
    mem_w = 1'b1; addr = 32'hFFFF0004; din = 32'hAAAA5555; dm_ctrl = 3'd0;
    #2 rst = 1'b0;
    #1;
    check("async_led", {16'h0, led}, 32'h0);
    check("async_err", {31'b0, store_err}, 32'h0);
    check("async_led_rd", dout, 32'h0);
    addr = 32'hFFFF0008; #1;
    check("async_misal_rd", dout, 32'h0);
    addr = 32'hFFFF0000; #1;
    check("async_cycle_rd", dout, 32'h0);
    addr = 32'h10; din = 32'h22222222;
    @(negedge clk);
    rst = 1'b1; mem_w = 1'b0; addr = 32'hFFFF0000;
    @(negedge clk);
    c1 = dout;
    check("cycle_after_rst", c1, 32'h1);
    repeat (5) @(negedge clk);
    c2 = dout;
    check("cycle_delta5", c2 - c1, 32'd5);
    check("led_no_write", {16'h0, led}, 32'h0);
    addr = 32'h10; #1;
    check("ram_no_write_rst", dout, 32'h11111111);

    // Randomized phase against the reference model.
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    m_led = '0; m_err = 1'b0; m_misal = '0;
    for (int i = 0; i < 4096; i++) known[i] = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 32; i++) cycle_op(1'b1, 32'(i * 4), $urandom, 3'd0);
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind == 6)      ra = 32'hFFFF0000 + $urandom_range(4, 15);
      else if (kind == 7) ra = $urandom_range(4096, 65535);
      else                ra = $urandom_range(0, 127);
      rw = 1'($urandom_range(0, 1));
      rd = $urandom;
      rc = 3'($urandom_range(0, 7));
      cycle_op(rw, ra, rd, rc);
    end
    mem_w = 1'b0; addr = 32'hFFFF0008; dm_ctrl = 3'd0;
    @(negedge clk);
    check("rand_misal_final", dout, m_misal);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
